bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NR_REQ, default 2, number of requesters sharing the memory port (2..8).
REQ-002 Parameter ADDR_LEN, default 32, address width.
REQ-003 Parameter DATA_LEN, default 32, data width.
REQ-004 clk  input  1  system clock; one clock domain, all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NR_REQ  per-requester request valid; bit i = requester i.
REQ-007 req_ready  output  NR_REQ  per-requester request accepted.
REQ-008 req_wen  input  NR_REQ  per-requester write enable (1 = write, 0 = read).
REQ-009 req_addr  input  NR_REQ*ADDR_LEN  flattened addresses; slice i = [ADDR_LEN*(i+1)-1 : ADDR_LEN*i].
REQ-010 req_wdata  input  NR_REQ*DATA_LEN  flattened write data, same slicing.
REQ-011 resp_valid  output  NR_REQ  per-requester response valid.
REQ-012 resp_ready  input  NR_REQ  per-requester response accept.
REQ-013 resp_rdata  output  DATA_LEN  shared read data; valid only with the granted requester's resp_valid bit.
REQ-014 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-015 mem_wen, mem_addr, mem_wdata  output  1, ADDR_LEN, DATA_LEN  muxed payload of the granted requester.
REQ-016 mem_resp_valid / mem_resp_ready  input / output  1 / 1  memory response handshake; mem_rdata input DATA_LEN.
REQ-017 grant_id  output  $clog2(NR_REQ) (min 1)  index of the current or last granted requester.

Function
REQ-018 FSM states: IDLE, REQ, RESP; one transaction outstanding at most.
REQ-019 IDLE: on any req_valid bit set, latch the winner index into grant_id, go to REQ next cycle; otherwise stay.
REQ-020 REQ: mem_req_valid=1; mem payload = slice grant_id of req_*; req_ready[grant_id]=mem_req_ready; on mem_req_valid&&mem_req_ready go to RESP.
REQ-021 RESP: resp_valid[grant_id]=mem_resp_valid; resp_rdata=mem_rdata; mem_resp_ready=resp_ready[grant_id]; on mem_resp_valid&&mem_resp_ready go to IDLE.
REQ-022 Non-granted requesters see req_ready=0 and resp_valid=0 in every state.
REQ-023 Latency: req_valid seen in IDLE at cycle N gives mem_req_valid=1 at N+1; zero-wait memory completes in 3 cycles, after which the next grant is decided in IDLE.
REQ-024 Requesters hold req_valid and payload stable until req_ready; the arbiter does not re-arbitrate in REQ even if req_valid[grant_id] drops.
REQ-025 mem_resp_valid outside RESP is ignored; mem_resp_ready=0 outside RESP.
REQ-026 Simultaneous requests: exactly one winner per IDLE cycle, chosen per REQ-031/032.
REQ-027 Pointer wrap: the priority pointer after a grant to NR_REQ-1 is 0.

Reset
REQ-028 rst_n low: state=IDLE, grant_id=0, priority pointer=0, immediately and asynchronously.
REQ-029 During reset: all outputs 0 (req_ready, resp_valid, mem_req_valid, mem_resp_ready, mem payload, resp_rdata).
REQ-030 Reset mid-transaction drops it; no response is delivered after rst_n deasserts.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: round-robin; the search starts at the pointer; the pointer becomes grant_id+1 (mod NR_REQ) on each RESP completion.
REQ-032 Macro undefined: fixed priority, the lowest set index wins; no pointer register exists.

Verification
REQ-033 Single: req_valid=2'b01, read addr 0x80000000, zero-wait memory, mem_rdata=0x1234 -> mem_req_valid at cycle 1, resp_valid=2'b01 with rdata 0x1234 at cycle 2, IDLE at cycle 3.
REQ-034 Contention, RR enabled: req_valid=2'b11 held for 4 transactions -> grant order 0,1,0,1.
REQ-035 Contention, RR disabled: req_valid=2'b11 held -> grant_id=0 on every grant; requester 1 starves.
REQ-036 Backpressure: mem_req_ready low 3 cycles, then resp_ready[1] low 2 cycles with mem_resp_valid=1 -> payload stable, req_ready[1]=0, no state change until the handshakes complete.
REQ-037 Reset: rst_n pulled low in RESP with NR_REQ=4, grant_id=3 -> all outputs 0 immediately; after release, req_valid=4'b1000 -> grant_id=3 and the pointer starts at 0.
REQ-038 Stray response: mem_resp_valid=1 in IDLE -> resp_valid=0, mem_resp_ready=0, state stays IDLE.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bundle of the requester-side and memory-side signals around bus_arbiter.
//
// Parameters
//   NR_REQ   number of requesters (2..8)
//   ADDR_LEN address width
//   DATA_LEN data width
//
// Signals
//   req_valid/req_ready/req_wen   per-requester request handshake + direction
//   req_addr/req_wdata            flattened payloads, slice i = [W*(i+1)-1 : W*i]
//   resp_valid/resp_ready         per-requester response handshake
//   resp_rdata                    shared read data
//   mem_req_valid/mem_req_ready   memory request handshake
//   mem_wen/mem_addr/mem_wdata    muxed payload of the granted requester
//   mem_resp_valid/mem_resp_ready memory response handshake, mem_rdata payload
//   grant_id                      current or last granted requester
//
// Modports
//   slave  : arbiter view (consumes requests and memory responses)
//   master : environment view (requesters plus memory model)

interface bus_arbiter_if #(
  parameter int unsigned NR_REQ   = 2,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
);

  localparam int unsigned GRANT_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  // Requester side
  logic [NR_REQ-1:0]          req_valid;
  logic [NR_REQ-1:0]          req_ready;
  logic [NR_REQ-1:0]          req_wen;
  logic [NR_REQ*ADDR_LEN-1:0] req_addr;
  logic [NR_REQ*DATA_LEN-1:0] req_wdata;
  logic [NR_REQ-1:0]          resp_valid;
  logic [NR_REQ-1:0]          resp_ready;
  logic [DATA_LEN-1:0]        resp_rdata;

  // Memory side
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic                       mem_wen;
  logic [ADDR_LEN-1:0]        mem_addr;
  logic [DATA_LEN-1:0]        mem_wdata;
  logic                       mem_resp_valid;
  logic                       mem_resp_ready;
  logic [DATA_LEN-1:0]        mem_rdata;

  // Status
  logic [GRANT_W-1:0]         grant_id;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_resp_ready,
    output grant_id
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_resp_ready,
    input  grant_id
  );

endinterface

// File: rtl/bus_arbiter.sv
// Arbiter sharing one memory port between NR_REQ requesters, one transaction
// outstanding at a time (IDLE -> REQ -> RESP -> IDLE).
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : round-robin search starting at a priority pointer; the pointer
//               moves to grant_id+1 (mod NR_REQ) when a response completes
//   undefined : fixed priority, lowest requester index wins, no pointer
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bus_arbiter_if.slave (requester and memory handshakes, grant_id)
//
// Handshake outputs are combinational from the registered state and the
// granted requester; grant_id is registered. While rst_n is low the state is
// IDLE, so every handshake and payload output is 0.

module bus_arbiter #(
  parameter int unsigned NR_REQ   = 2,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arbiter_if.slave bus
);

  localparam int unsigned GRANT_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [GRANT_W-1:0]  grant_q;
  logic [GRANT_W-1:0]  grant_nxt;
  logic [GRANT_W-1:0]  winner;
  logic                found;
  logic                any_req;
  logic [NR_REQ-1:0]   grant_oh;
  logic [ADDR_LEN-1:0] addr_arr  [NR_REQ];
  logic [DATA_LEN-1:0] wdata_arr [NR_REQ];

  // Unflatten the per-requester payloads so the mux is a plain array index
  for (genvar g = 0; g < NR_REQ; g++) begin : g_slice
    assign addr_arr[g]  = bus.req_addr[ADDR_LEN*g +: ADDR_LEN];
    assign wdata_arr[g] = bus.req_wdata[DATA_LEN*g +: DATA_LEN];
  end

  assign any_req      = |bus.req_valid;
  assign grant_oh     = NR_REQ'(1) << grant_q;
  assign bus.grant_id = grant_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic [GRANT_W-1:0] ptr_q;
  logic [GRANT_W-1:0] ptr_nxt;
  logic [GRANT_W-1:0] rr_idx;

  // Round-robin pick: first set request at or after the pointer, wrapping
  always_comb begin : p_winner
    winner = ptr_q;
    found  = 1'b0;
    rr_idx = ptr_q;
    for (int unsigned off = 0; off < NR_REQ; off++) begin
      rr_idx = GRANT_W'((32'(ptr_q) + off) % NR_REQ);
      if (!found && bus.req_valid[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  // Priority pointer
  always_ff @(posedge clk or negedge rst_n) begin : p_ptr
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end
`else
  // Fixed priority pick: lowest set index wins
  always_comb begin : p_winner
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (!found && bus.req_valid[GRANT_W'(i)]) begin
        winner = GRANT_W'(i);
        found  = 1'b1;
      end
    end
  end
`endif

  // State and grant registers
  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      state   <= ST_IDLE;
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
    end
  end

  // Next state, grant latch and handshake/payload routing
  always_comb begin : p_next
    state_nxt          = state;
    grant_nxt          = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_nxt            = ptr_q;
`endif
    bus.req_ready      = '0;
    bus.resp_valid     = '0;
    bus.resp_rdata     = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_wen        = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.mem_resp_ready = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Stray mem_resp_valid is ignored here: nothing is routed
        if (any_req) begin
          grant_nxt = winner;
          state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        // Grant is frozen; a dropped req_valid does not re-arbitrate
        bus.mem_req_valid = 1'b1;
        bus.mem_wen       = bus.req_wen[grant_q];
        bus.mem_addr      = addr_arr[grant_q];
        bus.mem_wdata     = wdata_arr[grant_q];
        bus.req_ready     = grant_oh & {NR_REQ{bus.mem_req_ready}};
        if (bus.mem_req_ready) begin
          state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        bus.resp_valid     = grant_oh & {NR_REQ{bus.mem_resp_valid}};
        bus.resp_rdata     = bus.mem_rdata;
        bus.mem_resp_ready = bus.resp_ready[grant_q];
        if (bus.mem_resp_valid && bus.resp_ready[grant_q]) begin
          state_nxt = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_nxt   = GRANT_W'((32'(grant_q) + 32'd1) % NR_REQ);
`endif
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Only the granted requester may ever see a handshake
  a_one_port: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready | bus.resp_valid));

  // The grant index always names a real requester
  a_grant_range: assert property (@(posedge clk) disable iff (!rst_n)
    32'(grant_q) < NR_REQ);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NR_REQ=4): a vector table of single
// transactions, then contention, backpressure, stray-response and
// mid-transaction reset sequences. A scoreboard queue holds the expected
// request/response of each transaction and is checked at every handshake.

module tb_bus_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned GW = 2;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NR_REQ(NR), .ADDR_LEN(AW), .DATA_LEN(DW)) bus ();

  bus_arbiter #(.NR_REQ(NR), .ADDR_LEN(AW), .DATA_LEN(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int resp_seen = 0;

  typedef struct {
    logic [GW-1:0] id;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [GW-1:0] id;
    logic [DW-1:0] rdata;
  } resp_exp_t;

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] wen;
    logic [DW-1:0] rdata;
    int            exp_fp;
    int            exp_rr;
  } vec_t;

  req_exp_t  req_q [$];
  resp_exp_t resp_q[$];
  req_exp_t  m_req;
  resp_exp_t m_resp;
  vec_t      vecs [12];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [AW-1:0] addr_of(input int id);
    return 32'h8000_0000 + AW'(id) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int id);
    return 32'hA5A5_0000 + DW'(id);
  endfunction

  function automatic logic [NR-1:0] oh(input int id);
    return NR'(1) << id;
  endfunction

  function automatic int pick(input int fp, input int rr);
    return RR_MODE ? rr : fp;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_valid      = '0;
    bus.req_wen        = '0;
    bus.resp_ready     = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic push_txn(input int id, input logic [NR-1:0] wen,
                          input logic [DW-1:0] rdata, input bit with_resp);
    req_q.push_back('{id: GW'(id), wen: wen[id], addr: addr_of(id), wdata: wdata_of(id)});
    if (with_resp) resp_q.push_back('{id: GW'(id), rdata: rdata});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},      64'(bus.req_ready),      64'd0);
    check({tag, "_resp_valid"},     64'(bus.resp_valid),     64'd0);
    check({tag, "_mem_req_valid"},  64'(bus.mem_req_valid),  64'd0);
    check({tag, "_mem_resp_ready"}, 64'(bus.mem_resp_ready), 64'd0);
    check({tag, "_mem_wen"},        64'(bus.mem_wen),        64'd0);
    check({tag, "_mem_addr"},       64'(bus.mem_addr),       64'd0);
    check({tag, "_mem_wdata"},      64'(bus.mem_wdata),      64'd0);
    check({tag, "_resp_rdata"},     64'(bus.resp_rdata),     64'd0);
    check({tag, "_grant_id"},       64'(bus.grant_id),       64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One zero-wait transaction with cycle-exact latency checks
  task automatic run_one(input logic [NR-1:0] valid, input logic [NR-1:0] wen,
                         input logic [DW-1:0] rdata, input int exp_id,
                         input string tag);
    step();
    bus.req_valid      = valid;
    bus.req_wen        = wen;
    bus.mem_rdata      = rdata;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.resp_ready     = '1;
    push_txn(exp_id, wen, rdata, 1'b1);
    @(negedge clk);
    check({tag, "_c0_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({tag, "_c0_resp_valid"},    64'(bus.resp_valid),    64'd0);
    step();
    @(negedge clk);
    check({tag, "_c1_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, "_c1_grant_id"},      64'(bus.grant_id),      64'(exp_id));
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check({tag, "_c2_resp_valid"},    64'(bus.resp_valid),    64'(oh(exp_id)));
    check({tag, "_c2_resp_rdata"},    64'(bus.resp_rdata),    64'(rdata));
    check({tag, "_c2_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    step();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check({tag, "_c3_mem_req_valid"},  64'(bus.mem_req_valid),  64'd0);
    check({tag, "_c3_resp_valid"},     64'(bus.resp_valid),     64'd0);
    check({tag, "_c3_mem_resp_ready"}, 64'(bus.mem_resp_ready), 64'd0);
  endtask

  // Scoreboard: compare every handshake against the queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (req_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_req: got request from grant %0d, expected none", bus.grant_id);
        end else begin
          m_req = req_q.pop_front();
          check("sb_req_grant", 64'(bus.grant_id),  64'(m_req.id));
          check("sb_req_wen",   64'(bus.mem_wen),   64'(m_req.wen));
          check("sb_req_addr",  64'(bus.mem_addr),  64'(m_req.addr));
          check("sb_req_wdata", 64'(bus.mem_wdata), 64'(m_req.wdata));
          check("sb_req_ready", 64'(bus.req_ready), 64'(oh(int'(m_req.id))));
        end
      end
      if ((bus.resp_valid & bus.resp_ready) != '0) begin
        resp_seen++;
        if (resp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_resp: got resp_valid 0x%0h, expected none", bus.resp_valid);
        end else begin
          m_resp = resp_q.pop_front();
          check("sb_resp_valid", 64'(bus.resp_valid),     64'(oh(int'(m_resp.id))));
          check("sb_resp_rdata", 64'(bus.resp_rdata),     64'(m_resp.rdata));
          check("sb_resp_ready", 64'(bus.mem_resp_ready), 64'd1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    int  target;
    bit  done;

    //            valid    wen      rdata          fp rr
    vecs[0]  = '{4'b0001, 4'b0000, 32'h0000_1234, 0, 0};
    vecs[1]  = '{4'b0010, 4'b0010, 32'h1111_0001, 1, 1};
    vecs[2]  = '{4'b0100, 4'b0000, 32'h2222_0002, 2, 2};
    vecs[3]  = '{4'b1000, 4'b1000, 32'h3333_0003, 3, 3};
    vecs[4]  = '{4'b1001, 4'b0001, 32'h4444_0004, 0, 0};
    vecs[5]  = '{4'b1001, 4'b1001, 32'h5555_0005, 0, 3};
    vecs[6]  = '{4'b0110, 4'b0110, 32'h6666_0006, 1, 1};
    vecs[7]  = '{4'b0110, 4'b0100, 32'h7777_0007, 1, 2};
    vecs[8]  = '{4'b1111, 4'b1010, 32'h8888_0008, 0, 3};
    vecs[9]  = '{4'b1111, 4'b0101, 32'h9999_0009, 0, 0};
    vecs[10] = '{4'b1100, 4'b1100, 32'hAAAA_000A, 2, 2};
    vecs[11] = '{4'b0011, 4'b0011, 32'hBBBB_000B, 0, 0};

    for (int i = 0; i < int'(NR); i++) begin
      bus.req_addr[AW*i +: AW]  = addr_of(i);
      bus.req_wdata[DW*i +: DW] = wdata_of(i);
    end

    // Reset with busy inputs: every output must still be 0
    rst_n              = 1'b0;
    bus.req_valid      = '1;
    bus.req_wen        = '1;
    bus.resp_ready     = '1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hFFFF_FFFF;
    #12;
    check_all_zero("reset");
    drive_idle();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_one(vecs[i].valid, vecs[i].wen, vecs[i].rdata,
              pick(vecs[i].exp_fp, vecs[i].exp_rr), $sformatf("vec%0d", i));
    end

    // Stray memory response in IDLE
    step();
    bus.mem_resp_valid = 1'b1;
    bus.resp_ready     = '1;
    bus.mem_rdata      = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_resp_valid",     64'(bus.resp_valid),     64'd0);
      check("stray_mem_resp_ready", 64'(bus.mem_resp_ready), 64'd0);
      check("stray_mem_req_valid",  64'(bus.mem_req_valid),  64'd0);
      check("stray_resp_rdata",     64'(bus.resp_rdata),     64'd0);
      step();
    end
    bus.mem_resp_valid = 1'b0;

    // Contention: requesters 0 and 1 held for four transactions
    do_reset();
    step();
    bus.req_valid      = 4'b0011;
    bus.req_wen        = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.resp_ready     = '1;
    bus.mem_rdata      = 32'h5555_AAAA;
    for (int k = 0; k < 4; k++) push_txn(RR_MODE ? (k % 2) : 0, 4'b0000, 32'h5555_AAAA, 1'b1);
    target = resp_seen + 4;
    done   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (resp_seen >= target) begin
        done = 1'b1;
        break;
      end
    end
    bus.req_valid      = '0;
    bus.mem_resp_valid = 1'b0;
    check("contention_done", 64'(done), 64'd1);

    // Backpressure on both memory handshakes, requester 1 writing
    bus.req_valid     = 4'b0010;
    bus.req_wen       = 4'b0010;
    bus.mem_req_ready = 1'b0;
    bus.resp_ready    = '1;
    bus.mem_rdata     = 32'h7777_0001;
    push_txn(1, 4'b0010, 32'h7777_0001, 1'b1);
    step();
    bus.req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
      check("bp_req_ready",     64'(bus.req_ready),     64'd0);
      check("bp_grant_id",      64'(bus.grant_id),      64'd1);
      check("bp_mem_addr",      64'(bus.mem_addr),      64'(addr_of(1)));
      check("bp_mem_wdata",     64'(bus.mem_wdata),     64'(wdata_of(1)));
      check("bp_mem_wen",       64'(bus.mem_wen),       64'd1);
      step();
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    step();
    bus.req_valid      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.resp_ready     = 4'b1101;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_resp_valid",     64'(bus.resp_valid),     64'h2);
      check("bp_mem_resp_ready", 64'(bus.mem_resp_ready), 64'd0);
      check("bp_resp_mem_req",   64'(bus.mem_req_valid),  64'd0);
      check("bp_resp_rdata",     64'(bus.resp_rdata),     64'h7777_0001);
      step();
    end
    bus.resp_ready = '1;
    @(negedge clk);
    step();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check("bp_end_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("bp_end_resp_valid",    64'(bus.resp_valid),    64'd0);

    // Reset in RESP with grant 3 after the pointer has moved
    do_reset();
    run_one(4'b0010, 4'b0000, 32'h0000_0001, 1, "pre_rst");
    step();
    bus.req_valid      = 4'b1000;
    bus.req_wen        = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.resp_ready     = '1;
    push_txn(3, 4'b0000, 32'h0, 1'b0);
    step();
    bus.req_valid = '0;
    step();
    @(negedge clk);
    check("rst_pre_grant_id",       64'(bus.grant_id),       64'd3);
    check("rst_pre_mem_resp_ready", 64'(bus.mem_resp_ready), 64'd1);
    #2;
    rst_n              = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAD0_BAD0;
    #1;
    check_all_zero("rst_async");
    step();
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_after_resp_valid",     64'(bus.resp_valid),     64'd0);
      check("rst_after_mem_resp_ready", 64'(bus.mem_resp_ready), 64'd0);
      step();
    end
    bus.mem_resp_valid = 1'b0;
    run_one(4'b1010, 4'b0000, 32'h0000_0002, 1, "post_rst_ptr");
    run_one(4'b1000, 4'b1000, 32'h0000_0003, 3, "post_rst_g3");

    step();
    check("sb_req_drained",  64'(req_q.size()),  64'd0);
    check("sb_resp_drained", 64'(resp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
